// File: rtl/operand_issue.sv
// rtl/operand_issue.sv - issue/writeback stage driving an external combinational alu
// Two-state loop: IDLE accepts and registers operands, EXEC writes the alu result back.
module operand_issue #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [7:0]       instr,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_sub,
   input  logic [WIDTH-1:0] alu_result,
   output logic             wb_valid,
   output logic [1:0]       wb_addr,
   output logic [WIDTH-1:0] wb_data,
   output logic             zero_flag,
   input  logic [1:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   typedef enum logic {S_IDLE, S_EXEC} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   state_t           r_state;
   logic [1:0]       r_op;
   logic [1:0]       r_rd;
   logic [WIDTH-1:0] r_regs [4];
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic             r_alu_sub;
   logic             r_wb_valid;
   logic [1:0]       r_wb_addr;
   logic [WIDTH-1:0] r_wb_data;
   logic             r_zero_flag;

   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_imm;
   logic [WIDTH-1:0] w_wb_value;

   assign w_op  = instr[7:6];
   assign w_imm = WIDTH'(instr[3:0]);
   // LDI keeps its immediate in alu_b, so writeback never depends on the alu for it.
   assign w_wb_value = (r_op == OP_LDI) ? r_alu_b : alu_result;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_op        <= OP_ADD;
         r_rd        <= 2'd0;
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sub   <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_addr   <= 2'd0;
         r_wb_data   <= '0;
         r_zero_flag <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_op    <= w_op;
                  r_rd    <= instr[5:4];
                  r_state <= S_EXEC;
                  if (w_op == OP_LDI) begin
                     r_alu_a   <= '0;
                     r_alu_b   <= w_imm;
                     r_alu_sub <= 1'b0;
                  end else begin
                     r_alu_a   <= r_regs[instr[3:2]];
                     r_alu_b   <= r_regs[instr[1:0]];
                     r_alu_sub <= (w_op == OP_SUB);
                  end
               end
            end
            S_EXEC: begin
               r_state <= S_IDLE;
               if (r_op != OP_NOP) begin
                  r_regs[r_rd] <= w_wb_value;
                  r_wb_valid   <= 1'b1;
                  r_wb_addr    <= r_rd;
                  r_wb_data    <= w_wb_value;
                  r_zero_flag  <= (w_wb_value == '0);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign instr_ready = (r_state == S_IDLE);
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_sub     = r_alu_sub;
   assign wb_valid    = r_wb_valid;
   assign wb_addr     = r_wb_addr;
   assign wb_data     = r_wb_data;
   assign zero_flag   = r_zero_flag;
   assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_operand_issue.sv
// tb/tb_operand_issue.sv - directed and random bench for operand_issue with a combinational alu model
module tb_operand_issue;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [7:0] instr = 8'h00;
   logic [3:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
   logic       alu_sub, wb_valid, zero_flag;
   logic [1:0] wb_addr;
   logic [1:0] dbg_addr = 2'd0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] m_regs [4];
   logic       m_zf;

   always #5 clk = ~clk;

   // The downstream alu: plain add or subtract, modulo 16.
   assign alu_result = alu_sub ? 4'(alu_a - alu_b) : 4'(alu_a + alu_b);

   operand_issue #(.WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_result(alu_result),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .zero_flag(zero_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected stage behaviour of one instruction against the current model registers.
   task automatic model_exp(input logic [7:0] w, output logic [3:0] ea, output logic [3:0] eb,
                            output logic es, output logic wr, output logic [3:0] d);
      case (w[7:6])
         2'b10: begin ea = 4'd0; eb = w[3:0]; es = 1'b0; d = w[3:0]; end
         2'b01: begin ea = m_regs[w[3:2]]; eb = m_regs[w[1:0]]; es = 1'b1; d = 4'(ea - eb); end
         default: begin ea = m_regs[w[3:2]]; eb = m_regs[w[1:0]]; es = 1'b0; d = 4'(ea + eb); end
      endcase
      wr = (w[7:6] != 2'b11);
   endtask

   task automatic after_accept(input logic [7:0] w);
      logic [3:0] ea, eb, d;
      logic es, wr;
      model_exp(w, ea, eb, es, wr, d);
      check("ready_exec", 8'(instr_ready), 8'd0);
      check("alu_a", 8'(alu_a), 8'(ea));
      check("alu_b", 8'(alu_b), 8'(eb));
      check("alu_sub", 8'(alu_sub), 8'(es));
      check("wb_valid_exec", 8'(wb_valid), 8'd0);
   endtask

   task automatic after_wb(input logic [7:0] w);
      logic [3:0] ea, eb, d;
      logic es, wr;
      model_exp(w, ea, eb, es, wr, d);
      if (wr) begin
         m_regs[w[5:4]] = d;
         m_zf = (d == 4'd0);
      end
      check("wb_valid", 8'(wb_valid), 8'(wr));
      if (wr) begin
         check("wb_addr", 8'(wb_addr), 8'(w[5:4]));
         check("wb_data", 8'(wb_data), 8'(d));
      end
      check("zero_flag", 8'(zero_flag), 8'(m_zf));
      check("ready_idle", 8'(instr_ready), 8'd1);
      check("dbg_data", 8'(dbg_data), 8'(m_regs[dbg_addr]));
   endtask

   task automatic run_instr(input logic [7:0] w);
      @(negedge clk);
      instr_valid = 1'b1;
      instr = w;
      dbg_addr = w[5:4];
      check("ready_before", 8'(instr_ready), 8'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = 8'($urandom);
      after_accept(w);
      @(posedge clk); #1;
      after_wb(w);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      m_zf = 1'b0;
      check("rst_ready", 8'(instr_ready), 8'd1);
      check("rst_alu_a", 8'(alu_a), 8'd0);
      check("rst_alu_b", 8'(alu_b), 8'd0);
      check("rst_alu_sub", 8'(alu_sub), 8'd0);
      check("rst_wb_valid", 8'(wb_valid), 8'd0);
      check("rst_wb_addr", 8'(wb_addr), 8'd0);
      check("rst_wb_data", 8'(wb_data), 8'd0);
      check("rst_zero_flag", 8'(zero_flag), 8'd0);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1 check("rst_dbg", 8'(dbg_data), 8'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [7:0] w;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      m_zf = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // Load and add
      run_instr(8'h95);
      run_instr(8'hA3);
      run_instr(8'h36);
      check("add_result", 8'(wb_data), 8'd8);
      check("add_zf", 8'(zero_flag), 8'd0);

      // Subtract wrap, zero, then NOP
      run_instr(8'h49);
      check("sub_wrap", 8'(wb_data), 8'hE);
      run_instr(8'h45);
      check("sub_zero", 8'(wb_data), 8'd0);
      check("sub_zf", 8'(zero_flag), 8'd1);
      run_instr(8'hC0);
      check("nop_zf", 8'(zero_flag), 8'd1);

      // Back-to-back dependent ADD r1,r1,r1 with valid held high
      @(negedge clk);
      instr_valid = 1'b1;
      instr = 8'h15;
      dbg_addr = 2'd1;
      check("b2b_ready0", 8'(instr_ready), 8'd1);
      @(posedge clk); #1;
      after_accept(8'h15);
      @(posedge clk); #1;
      after_wb(8'h15);
      check("b2b_first", 8'(wb_data), 8'd10);
      @(posedge clk); #1;
      after_accept(8'h15);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      after_wb(8'h15);
      check("b2b_second", 8'(wb_data), 8'd4);

      // Reset during EXEC aborts the write
      run_instr(8'h93);
      run_instr(8'hA7);
      @(negedge clk);
      instr_valid = 1'b1;
      instr = 8'h36;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      after_accept(8'h36);
      do_reset();
      @(posedge clk); #1;
      check("abort_wb_valid", 8'(wb_valid), 8'd0);
      dbg_addr = 2'd3;
      #1 check("abort_r3", 8'(dbg_data), 8'd0);

      // Stall hold: word X presented during EXEC must wait for IDLE and run once
      run_instr(8'h9C);
      @(negedge clk);
      instr_valid = 1'b1;
      instr = 8'h39;
      dbg_addr = 2'd3;
      @(posedge clk); #1;
      after_accept(8'h39);
      instr = 8'hA7;
      @(posedge clk); #1;
      after_wb(8'h39);
      dbg_addr = 2'd2;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      after_accept(8'hA7);
      @(posedge clk); #1;
      after_wb(8'hA7);
      @(posedge clk); #1;
      check("stall_once_wb", 8'(wb_valid), 8'd0);
      check("stall_once_ready", 8'(instr_ready), 8'd1);

      // Random instruction stream with idle gaps
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            instr_valid = 1'b0;
            instr = 8'($urandom);
         end
         w = 8'($urandom);
         run_instr(w);
      end

      // Mid-run reset
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
